// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb_pkg: shared widths and the hard-wired zero register index
package reg_file_sb_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS = 32;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// reg_scoreboard: per-register busy bits, operand hazard detection and issue acceptance
module reg_scoreboard
  import reg_file_sb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic              rs1_use,
  input  logic              rs2_use,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              stall,
  output logic              issue_ack,
  output logic [NREGS-1:0]  busy_vec
);
  logic [NREGS-1:0] busy_nxt;
  logic haz1, haz2, wr_ok;
  assign wr_ok = wr_en & (wr_addr != REG_ZERO);
  assign haz1 = rs1_use & (rs1_addr != REG_ZERO) & busy_vec[rs1_addr] & ~(wr_en & (wr_addr == rs1_addr));
  assign haz2 = rs2_use & (rs2_addr != REG_ZERO) & busy_vec[rs2_addr] & ~(wr_en & (wr_addr == rs2_addr));
  assign stall = haz1 | haz2;
  assign issue_ack = issue_en & ~stall & ~reset;
  // writeback retires a producer, then a new issue claims the register so it wins a same-cycle collision
  always_comb begin
    busy_nxt = busy_vec;
    if (wr_ok) busy_nxt[wr_addr] = 1'b0;
    if (issue_ack && issue_rd != REG_ZERO) busy_nxt[issue_rd] = 1'b1;
  end
  // busy state register, cleared immediately by reset
  always_ff @(posedge clk or posedge reset)
    if (reset) busy_vec <= '0;
    else busy_vec <= busy_nxt;
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: 32x32 register file with write-through bypass reads and a write-pending scoreboard
module reg_file_sb
  import reg_file_sb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              rs1_use,
  input  logic              rs2_use,
  output logic              stall,
  output logic              issue_ack,
  output logic [NREGS-1:0]  busy_vec
);
  logic [DATA_W-1:0] regs [NREGS];
  logic wr_ok;
  assign wr_ok = wr_en & (wr_addr != REG_ZERO);
  // storage: register 0 is never written so it stays at its reset value of zero
  always_ff @(posedge clk or posedge reset)
    if (reset) regs <= '{default: '0};
    else if (wr_ok) regs[wr_addr] <= wr_data;
  // read ports forward the in-flight writeback so decode sees it in the same cycle
  always_comb begin
    rs1_data = (reset || rs1_addr == REG_ZERO) ? '0 : (wr_ok && wr_addr == rs1_addr) ? wr_data : regs[rs1_addr];
    rs2_data = (reset || rs2_addr == REG_ZERO) ? '0 : (wr_ok && wr_addr == rs2_addr) ? wr_data : regs[rs2_addr];
  end
  reg_scoreboard u_sb (
    .clk(clk),
    .reset(reset),
    .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr),
    .rs1_use(rs1_use),
    .rs2_use(rs2_use),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .issue_en(issue_en),
    .issue_rd(issue_rd),
    .stall(stall),
    .issue_ack(issue_ack),
    .busy_vec(busy_vec)
  );
endmodule
